// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the WISC hazard controller: sequencing states and the
// destination-scoreboard entry layout.
package hazard_ctrl_pkg;

  localparam int unsigned REG_AW = 3;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] dst;
  } sb_entry_t;

  // True when a live entry writes register r.
  function automatic logic entry_hit(sb_entry_t e, logic [REG_AW-1:0] r);
    return e.valid && (e.dst == r);
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Two-entry destination scoreboard tracking producers in EX and MEM, with
// the source-register match comparators for the instruction in ID.
module hazard_scoreboard
  import hazard_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_shift,
  input  logic              i_wr_valid,
  input  logic [REG_AW-1:0] i_wr_dst,
  input  logic [REG_AW-1:0] i_rs,
  input  logic [REG_AW-1:0] i_rt,
  output logic              o_rs_hit,
  output logic              o_rt_hit,
  output logic              o_empty
);

  sb_entry_t r_ex;
  sb_entry_t r_mem;

  // Advance the EX->MEM shift pipeline on every unfrozen cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ex  <= '0;
      r_mem <= '0;
    end else if (i_shift) begin
      r_mem <= r_ex;
      r_ex  <= '{valid: i_wr_valid, dst: i_wr_dst};
    end
  end

  // Compare both ID sources against both in-flight producers.
  always_comb begin
    o_rs_hit = entry_hit(r_ex, i_rs) | entry_hit(r_mem, i_rs);
    o_rt_hit = entry_hit(r_ex, i_rt) | entry_hit(r_mem, i_rt);
    o_empty  = ~r_ex.valid & ~r_mem.valid;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// WISC 5-stage pipeline hazard controller: RAW decode stalls, redirect
// squash, memory-stall freeze, halt drain sequencing and perf counters.
module hazard_ctrl #(
  parameter int unsigned REG_AW = hazard_ctrl_pkg::REG_AW,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic              id_reg_wrt,
  input  logic [REG_AW-1:0] id_dst,
  input  logic              id_halt,
  input  logic              ex_redirect,
  input  logic              mem_stall,
  output logic              stall_ID,
  output logic              pc_write_en,
  output logic              ifid_write_en,
  output logic              flush_IFID,
  output logic              halt_done,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_count
);

  import hazard_ctrl_pkg::*;

  state_e           r_state;
  logic             r_halt_done;
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_flush_count;

  logic w_rs_hit;
  logic w_rt_hit;
  logic w_sb_empty;
  logic w_run;
  logic w_raw;
  logic w_issue;

  assign w_run   = (r_state == ST_RUN);
  assign w_raw   = id_valid & w_run &
                   ((id_rs_used & w_rs_hit) | (id_rt_used & w_rt_hit));
  assign w_issue = id_valid & ~stall_ID;

  hazard_scoreboard u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .i_shift    (~mem_stall),
    .i_wr_valid (w_issue & id_reg_wrt),
    .i_wr_dst   (id_dst),
    .i_rs       (id_rs),
    .i_rt       (id_rt),
    .o_rs_hit   (w_rs_hit),
    .o_rt_hit   (w_rt_hit),
    .o_empty    (w_sb_empty)
  );

  // Pipeline control priority: memory freeze, redirect, halt, RAW, run.
  always_comb begin
    stall_ID      = 1'b0;
    pc_write_en   = 1'b1;
    ifid_write_en = 1'b1;
    flush_IFID    = 1'b0;
    if (mem_stall) begin
      pc_write_en   = 1'b0;
      ifid_write_en = 1'b0;
    end else if (ex_redirect) begin
      stall_ID   = 1'b1;
      flush_IFID = 1'b1;
    end else if (!w_run || w_raw) begin
      stall_ID      = 1'b1;
      pc_write_en   = 1'b0;
      ifid_write_en = 1'b0;
    end
  end

  // Halt sequencing and saturating counters; everything holds on mem_stall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= ST_RUN;
      r_halt_done    <= 1'b0;
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else if (!mem_stall) begin
      if (ex_redirect) begin
        r_state     <= ST_RUN;
        r_halt_done <= 1'b0;
        if (r_flush_count != '1) r_flush_count <= r_flush_count + CNT_W'(1);
      end else begin
        unique case (r_state)
          ST_RUN: begin
            if (w_raw) begin
              if (r_stall_cycles != '1) r_stall_cycles <= r_stall_cycles + CNT_W'(1);
            end else if (id_halt && w_issue) begin
              r_state <= ST_DRAIN;
            end
          end
          ST_DRAIN: begin
            if (w_sb_empty) begin
              r_state     <= ST_HALTED;
              r_halt_done <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign halt_done    = r_halt_done;
  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized
// traffic against a behavioural model built on a queue of recent issue slots.
module tb_hazard_ctrl;

  localparam int unsigned AW  = 3;
  localparam int unsigned CW  = 10;
  localparam int          SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid, id_rs_used, id_rt_used, id_reg_wrt, id_halt;
  logic [AW-1:0] id_rs, id_rt, id_dst;
  logic          ex_redirect, mem_stall;
  logic          stall_ID, pc_write_en, ifid_write_en, flush_IFID, halt_done;
  logic [CW-1:0] stall_cycles, flush_count;

  hazard_ctrl #(.REG_AW(AW), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_rs_used   (id_rs_used),
    .id_rt_used   (id_rt_used),
    .id_reg_wrt   (id_reg_wrt),
    .id_dst       (id_dst),
    .id_halt      (id_halt),
    .ex_redirect  (ex_redirect),
    .mem_stall    (mem_stall),
    .stall_ID     (stall_ID),
    .pc_write_en  (pc_write_en),
    .ifid_write_en(ifid_write_en),
    .flush_IFID   (flush_IFID),
    .halt_done    (halt_done),
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: destinations written by the last two issue slots (-1 = none),
  // sequencing mode 0=run 1=drain 2=halted, and the two counters.
  int m_slot[$];
  int m_mode;
  int m_scnt;
  int m_fcnt;

  function automatic bit m_hit(int r);
    foreach (m_slot[i]) if (m_slot[i] == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_raw();
    return id_valid && (m_mode == 0) &&
           ((id_rs_used && m_hit(int'(id_rs))) || (id_rt_used && m_hit(int'(id_rt))));
  endfunction

  // Expected {stall_ID, pc_write_en, ifid_write_en, flush_IFID, halt_done}.
  function automatic logic [4:0] m_outs();
    logic h;
    h = (m_mode == 2);
    if (mem_stall)                 return {4'b0000, h};
    if (ex_redirect)               return {4'b1111, h};
    if (m_mode != 0 || m_raw())    return {4'b1000, h};
    return {4'b0110, h};
  endfunction

  function automatic logic [4:0] dut_outs();
    return {stall_ID, pc_write_en, ifid_write_en, flush_IFID, halt_done};
  endfunction

  task automatic m_reset();
    m_slot = '{-1, -1};
    m_mode = 0;
    m_scnt = 0;
    m_fcnt = 0;
  endtask

  // Apply one clock edge's worth of behaviour to the model.
  task automatic m_step();
    logic [4:0] e;
    bit issue, empty, hazard;
    if (mem_stall) return;
    e      = m_outs();
    hazard = m_raw();
    issue  = id_valid && !e[4];
    empty  = (m_slot[0] < 0) && (m_slot[1] < 0);
    if (ex_redirect) begin
      if (m_fcnt < SAT) m_fcnt++;
      m_mode = 0;
    end else if (m_mode == 0) begin
      if (hazard) begin
        if (m_scnt < SAT) m_scnt++;
      end else if (id_halt && issue) begin
        m_mode = 1;
      end
    end else if (m_mode == 1 && empty) begin
      m_mode = 2;
    end
    m_slot.push_front((issue && id_reg_wrt) ? int'(id_dst) : -1);
    void'(m_slot.pop_back());
  endtask

  task automatic drive(input bit v, input int rs, input bit rsu, input int rt,
                       input bit rtu, input bit w, input int d, input bit h);
    id_valid   = v;
    id_rs      = AW'(rs);
    id_rs_used = rsu;
    id_rt      = AW'(rt);
    id_rt_used = rtu;
    id_reg_wrt = w;
    id_dst     = AW'(d);
    id_halt    = h;
  endtask

  task automatic idle();
    drive(1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic do_reset();
    idle();
    ex_redirect = 1'b0;
    mem_stall   = 1'b0;
    rst = 1'b0;
    #2;
    rst = 1'b1;
    m_reset();
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [4:0] obs, ev;
    idle();
    ex_redirect = 1'b0;
    mem_stall   = 1'b0;
    rst = 1'b0;
    #1;
    obs = dut_outs();
    n_cmp++; if (obs !== 5'b01100) begin n_bad++; $display("FAIL reset_outs: got %b want %b", obs, 5'b01100); end
    n_cmp++; if (stall_cycles !== '0) begin n_bad++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cycles); end
    n_cmp++; if (flush_count !== '0) begin n_bad++; $display("FAIL reset_flush_cnt: got %0d want 0", flush_count); end
    #1;
    rst = 1'b1;
    m_reset();
    @(negedge clk);
    #1;
    obs = dut_outs(); ev = m_outs();
    n_cmp++; if (obs !== ev) begin n_bad++; $display("FAIL reset_release: got %b want %b", obs, ev); end
    m_step();
    @(negedge clk);
  endtask

  // Producer of dst, gap independent instructions, then a reader of dst.
  task automatic test_raw_distance(input int dst, input int gap, input bit via_rt, input int want);
    logic [4:0] obs, ev;
    int  stalls;
    bit  done;
    do_reset();
    drive(1'b1, (dst + 1) % 8, 1'b1, (dst + 2) % 8, 1'b1, 1'b1, dst, 1'b0);
    #1; obs = dut_outs(); ev = m_outs();
    n_cmp++; if (obs !== ev) begin n_bad++; $display("FAIL raw_producer: got %b want %b", obs, ev); end
    m_step(); @(negedge clk);
    for (int g = 0; g < gap; g++) begin
      drive(1'b1, 0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
      #1; obs = dut_outs(); ev = m_outs();
      n_cmp++; if (obs !== ev) begin n_bad++; $display("FAIL raw_gap: got %b want %b", obs, ev); end
      m_step(); @(negedge clk);
    end
    stalls = 0;
    done   = 1'b0;
    for (int c = 0; c < 8 && !done; c++) begin
      if (via_rt) drive(1'b1, (dst + 4) % 8, 1'b1, dst, 1'b1, 1'b0, 0, 1'b0);
      else        drive(1'b1, dst, 1'b1, (dst + 4) % 8, 1'b0, 1'b0, 0, 1'b0);
      #1; obs = dut_outs(); ev = m_outs();
      n_cmp++; if (obs !== ev) begin n_bad++; $display("FAIL raw_reader gap=%0d: got %b want %b", gap, obs, ev); end
      if (obs[4] && !obs[3]) stalls++;
      done = !ev[4];
      m_step(); @(negedge clk);
    end
    idle();
    #1;
    n_cmp++; if (stalls != want) begin n_bad++; $display("FAIL raw_stall_len gap=%0d: got %0d want %0d", gap, stalls, want); end
    n_cmp++; if (stall_cycles !== CW'(want)) begin n_bad++; $display("FAIL raw_stall_cnt gap=%0d: got %0d want %0d", gap, stall_cycles, want); end
    m_step(); @(negedge clk);
  endtask

  task automatic test_redirect_over_raw();
    logic [4:0] obs, ev;
    do_reset();
    drive(1'b1, 1, 1'b1, 2, 1'b1, 1'b1, 3, 1'b0);
    #1; m_step(); @(negedge clk);
    drive(1'b1, 3, 1'b1, 0, 1'b0, 1'b0, 0, 1'b0);
    ex_redirect = 1'b1;
    #1; obs = dut_outs(); ev = m_outs();
    n_cmp++; if (obs !== 5'b11110) begin n_bad++; $display("FAIL redirect_outs: got %b want %b", obs, 5'b11110); end
    n_cmp++; if (obs !== ev) begin n_bad++; $display("FAIL redirect_model: got %b want %b", obs, ev); end
    m_step(); @(negedge clk);
    ex_redirect = 1'b0;
    idle();
    #1;
    n_cmp++; if (stall_cycles !== CW'(0)) begin n_bad++; $display("FAIL redirect_stall_cnt: got %0d want 0", stall_cycles); end
    n_cmp++; if (flush_count !== CW'(1)) begin n_bad++; $display("FAIL redirect_flush_cnt: got %0d want 1", flush_count); end
    m_step(); @(negedge clk);
  endtask

  task automatic test_halt_drain();
    logic [4:0] obs, ev;
    int drain, halted;
    do_reset();
    drive(1'b1, 0, 1'b0, 0, 1'b0, 1'b1, 1, 1'b0);
    #1; m_step(); @(negedge clk);
    drive(1'b1, 0, 1'b0, 0, 1'b0, 1'b1, 2, 1'b0);
    #1; m_step(); @(negedge clk);
    drive(1'b1, 0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b1);
    #1; obs = dut_outs();
    n_cmp++; if (obs !== 5'b01100) begin n_bad++; $display("FAIL halt_issue: got %b want %b", obs, 5'b01100); end
    m_step(); @(negedge clk);
    idle();
    drain  = 0;
    halted = 0;
    for (int c = 0; c < 8; c++) begin
      #1; obs = dut_outs(); ev = m_outs();
      n_cmp++; if (obs !== ev) begin n_bad++; $display("FAIL halt_seq c=%0d: got %b want %b", c, obs, ev); end
      if (obs[4] && !obs[3] && !obs[0]) drain++;
      if (obs[0]) halted++;
      m_step(); @(negedge clk);
    end
    n_cmp++; if (drain != 2) begin n_bad++; $display("FAIL halt_drain_len: got %0d want 2", drain); end
    n_cmp++; if (halted != 6) begin n_bad++; $display("FAIL halt_done_held: got %0d want 6", halted); end
  endtask

  task automatic test_mem_stall_raw();
    logic [4:0] obs, ev;
    int  stalls;
    bit  done;
    do_reset();
    drive(1'b1, 1, 1'b1, 2, 1'b1, 1'b1, 3, 1'b0);
    #1; m_step(); @(negedge clk);
    drive(1'b1, 3, 1'b1, 0, 1'b0, 1'b0, 0, 1'b0);
    #1; obs = dut_outs(); ev = m_outs();
    n_cmp++; if (obs !== ev) begin n_bad++; $display("FAIL memstall_first: got %b want %b", obs, ev); end
    m_step(); @(negedge clk);
    mem_stall = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1; obs = dut_outs();
      n_cmp++; if (obs !== 5'b00000) begin n_bad++; $display("FAIL memstall_outs c=%0d: got %b want %b", c, obs, 5'b00000); end
      n_cmp++; if (stall_cycles !== CW'(1)) begin n_bad++; $display("FAIL memstall_frozen c=%0d: got %0d want 1", c, stall_cycles); end
      m_step(); @(negedge clk);
    end
    mem_stall = 1'b0;
    stalls = 0;
    done   = 1'b0;
    for (int c = 0; c < 6 && !done; c++) begin
      #1; obs = dut_outs(); ev = m_outs();
      n_cmp++; if (obs !== ev) begin n_bad++; $display("FAIL memstall_resume: got %b want %b", obs, ev); end
      if (obs[4] && !obs[3]) stalls++;
      done = !ev[4];
      m_step(); @(negedge clk);
    end
    idle();
    #1;
    n_cmp++; if (stalls != 1) begin n_bad++; $display("FAIL memstall_remaining: got %0d want 1", stalls); end
    n_cmp++; if (stall_cycles !== CW'(2)) begin n_bad++; $display("FAIL memstall_total: got %0d want 2", stall_cycles); end
    m_step(); @(negedge clk);
  endtask

  task automatic test_saturation_reset_drain();
    logic [4:0] obs, ev;
    do_reset();
    // Self-dependent R3 update keeps the RAW stall recurring.
    for (int c = 0; c < 1700; c++) begin
      drive(1'b1, 3, 1'b1, 0, 1'b0, 1'b1, 3, 1'b0);
      #1; obs = dut_outs(); ev = m_outs();
      n_cmp++; if (obs !== ev) begin n_bad++; $display("FAIL sat_stall_outs c=%0d: got %b want %b", c, obs, ev); end
      m_step(); @(negedge clk);
    end
    idle();
    #1;
    n_cmp++; if (stall_cycles !== CW'(SAT)) begin n_bad++; $display("FAIL sat_stall_cnt: got %0d want %0d", stall_cycles, SAT); end
    m_step(); @(negedge clk);
    ex_redirect = 1'b1;
    for (int c = 0; c < SAT + 20; c++) begin
      #1; m_step(); @(negedge clk);
    end
    ex_redirect = 1'b0;
    #1;
    n_cmp++; if (flush_count !== CW'(SAT)) begin n_bad++; $display("FAIL sat_flush_cnt: got %0d want %0d", flush_count, SAT); end
    m_step(); @(negedge clk);
    drive(1'b1, 0, 1'b0, 0, 1'b0, 1'b1, 1, 1'b0);
    #1; m_step(); @(negedge clk);
    drive(1'b1, 0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b1);
    #1; m_step(); @(negedge clk);
    idle();
    #1; obs = dut_outs();
    n_cmp++; if (obs !== 5'b10000) begin n_bad++; $display("FAIL drain_before_rst: got %b want %b", obs, 5'b10000); end
    n_cmp++; if (stall_cycles !== CW'(SAT)) begin n_bad++; $display("FAIL drain_cnt_before_rst: got %0d want %0d", stall_cycles, SAT); end
    #2;
    rst = 1'b0;
    #1;
    obs = dut_outs();
    n_cmp++; if (obs !== 5'b01100) begin n_bad++; $display("FAIL async_rst_outs: got %b want %b", obs, 5'b01100); end
    n_cmp++; if (stall_cycles !== '0) begin n_bad++; $display("FAIL async_rst_stall_cnt: got %0d want 0", stall_cycles); end
    n_cmp++; if (flush_count !== '0) begin n_bad++; $display("FAIL async_rst_flush_cnt: got %0d want 0", flush_count); end
    @(negedge clk);
    rst = 1'b1;
    m_reset();
  endtask

  task automatic test_random();
    logic [4:0] obs, ev;
    bit prev_ms, prev_red;
    do_reset();
    prev_ms  = 1'b0;
    prev_red = 1'b0;
    for (int c = 0; c < 600; c++) begin
      drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
            int'($urandom_range(0, 7)), $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0,
            int'($urandom_range(0, 7)), 1'b0);
      mem_stall   = ($urandom_range(0, 4) == 0);
      ex_redirect = (prev_ms && prev_red) ? 1'b1 : ($urandom_range(0, 7) == 0);
      prev_ms  = mem_stall;
      prev_red = ex_redirect;
      #1; obs = dut_outs(); ev = m_outs();
      n_cmp++; if (obs !== ev) begin n_bad++; $display("FAIL rand_outs c=%0d: got %b want %b", c, obs, ev); end
      n_cmp++; if (stall_cycles !== CW'(m_scnt)) begin n_bad++; $display("FAIL rand_stall_cnt c=%0d: got %0d want %0d", c, stall_cycles, m_scnt); end
      n_cmp++; if (flush_count !== CW'(m_fcnt)) begin n_bad++; $display("FAIL rand_flush_cnt c=%0d: got %0d want %0d", c, flush_count, m_fcnt); end
      m_step(); @(negedge clk);
    end
    idle();
    ex_redirect = 1'b0;
    mem_stall   = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    idle();
    ex_redirect = 1'b0;
    mem_stall   = 1'b0;
    m_reset();
    @(negedge clk);
    test_reset();
    test_raw_distance(3, 0, 1'b0, 2);
    test_raw_distance(5, 1, 1'b1, 1);
    test_raw_distance(5, 2, 1'b1, 0);
    test_redirect_over_raw();
    test_halt_drain();
    test_mem_stall_raw();
    test_saturation_reset_drain();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard and sequencing controller for the 5-stage WISC pipeline: IF, ID, EX, MEM, WB.
- Keeps a destination-register scoreboard for instructions in EX and MEM. Produces the decode-stage stall that turns the ID instruction into a NOP.
- Squashes wrong-path instructions when EX resolves a redirect, freezes the pipeline on memory stalls, and sequences halt drain.
- The register file bypasses WB to ID, so only EX and MEM producers cause RAW stalls.

Parameters:
REG_AW, 3, register address width (8 GPRs; R0 is a real register, no zero exemption)
CNT_W, 16, width of the saturating performance counters

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  asynchronous, active-low reset
id_valid  input  1  ID holds a real instruction (not a bubble)
id_rs  input  REG_AW  source-1 register of the ID instruction
id_rt  input  REG_AW  source-2 register of the ID instruction
id_rs_used  input  1  ID instruction reads id_rs
id_rt_used  input  1  ID instruction reads id_rt
id_reg_wrt  input  1  ID instruction writes a register
id_dst  input  REG_AW  ID write-back destination
id_halt  input  1  ID instruction is HALT
ex_redirect  input  1  EX resolved a taken branch or jump this cycle
mem_stall  input  1  data memory busy; freeze the whole pipeline
stall_ID  output  1  replace the ID instruction with a NOP into EX
pc_write_en  output  1  PC may update
ifid_write_en  output  1  IF/ID latch may load
flush_IFID  output  1  load a NOP into IF/ID
halt_done  output  1  halted and pipeline drained
stall_cycles  output  CNT_W  RAW stall cycle count, saturating
flush_count  output  CNT_W  redirect count, saturating

Behaviour:
Reset:
- State RUN; scoreboard entries invalid; counters 0; halt_done=0.
- With mem_stall=0: stall_ID=0, pc_write_en=1, ifid_write_en=1, flush_IFID=0.

Scoreboard:
- Two entries, EX={ex_v, ex_d} and MEM={mem_v, mem_d}.
- Each unfrozen cycle: MEM <= EX; EX <= {issue & id_reg_wrt, id_dst}.
- issue = id_valid & ~stall_ID.

RAW hazard (combinational, same cycle):
- raw = id_valid & state==RUN & ((id_rs_used & match(id_rs)) | (id_rt_used & match(id_rt))).
- match(r) = (ex_v & ex_d==r) | (mem_v & mem_d==r).
- Required stall lengths: producer at distance 1 gives 2 stall cycles; distance 2 gives 1; distance ≥3 gives 0.

Output priority (highest first):
1. mem_stall: all outputs 0 except halt_done; scoreboard, FSM and counters hold. ex_redirect is ignored while mem_stall=1; its source holds it asserted.
2. ex_redirect: flush_IFID=1, stall_ID=1 (the ID instruction is squashed, including HALT and RAW stalls), pc_write_en=1, ifid_write_en=1, flush_count++. Any halt is cancelled: state returns to RUN.
3. raw: stall_ID=1, pc_write_en=0, ifid_write_en=0, stall_cycles++.
4. Otherwise all enables are 1.

FSM:
- RUN -> DRAIN when the HALT in ID issues (id_halt & issue). That HALT enters EX normally.
- DRAIN and HALTED: stall_ID=1, pc_write_en=0, ifid_write_en=0.
- DRAIN -> HALTED once the scoreboard empties, i.e. EX and MEM both hold bubbles; this takes 2 unfrozen cycles.
- HALTED: halt_done=1; held until reset.

Counters:
- Saturate at all-ones; no wrap.

Reset mid-operation:
- Asynchronous clear at any point, including mid-stall or in DRAIN.
- Outputs take their reset values immediately, without waiting for a clock edge.

Decomposition:
- Shared package: REG_AW, the state encoding (RUN, DRAIN, HALTED), and the scoreboard entry struct {valid, dst}.
- One sub-module, hazard_scoreboard: the two-entry shift pipeline plus the match comparators.
- FSM, priority mux and counters stay in hazard_ctrl.

Test Plan:
- ADD R3 issues, next instruction reads R3 via rs -> stall_ID=1 and pc_write_en=0 for exactly 2 cycles, stall_cycles=2.
- Producer of R5, one independent instruction, then reader of R5 on rt -> 1 stall cycle; with two independent instructions in between -> 0 stalls.
- RAW stall active and ex_redirect=1 in the same cycle -> flush_IFID=1, stall_ID=1, pc_write_en=1, stall_cycles unchanged, flush_count=1.
- HALT issues with producers still in EX and MEM -> DRAIN for 2 cycles, then halt_done=1 stays high; a later ex_redirect is impossible since EX is empty.
- mem_stall held 4 cycles during a RAW stall -> all enables 0, scoreboard frozen; after release the remaining stall cycles complete unchanged.
- rst driven low in DRAIN with counters at 0xFFFF -> counters 0, state RUN, halt_done=0 immediately; stall_cycles saturation at 0xFFFF checked beforehand.
